// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI-lite slave port between N_MASTERS requesters. AR and AW/W are arbitrated
// independently round-robin. R returns by the ID tag, and B returns through a FIFO of write grants.
module axi_lite_master_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int M_ID_WIDTH = 2,
   parameter int IDX_W      = $clog2(N_MASTERS),
   parameter int S_ID_WIDTH = M_ID_WIDTH + IDX_W,
   parameter int B_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_araddr,
   input  logic [N_MASTERS*M_ID_WIDTH-1:0]  m_arid,
   input  logic [N_MASTERS-1:0]             m_arvalid,
   output logic [N_MASTERS-1:0]             m_arready,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_awaddr,
   input  logic [N_MASTERS-1:0]             m_awvalid,
   output logic [N_MASTERS-1:0]             m_awready,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
   input  logic [N_MASTERS-1:0]             m_wvalid,
   output logic [N_MASTERS-1:0]             m_wready,
   output logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata,
   output logic [N_MASTERS*M_ID_WIDTH-1:0]  m_rid,
   output logic [N_MASTERS-1:0]             m_rvalid,
   input  logic [N_MASTERS-1:0]             m_rready,
   output logic [N_MASTERS-1:0]             m_bvalid,
   input  logic [N_MASTERS-1:0]             m_bready,
   output logic [ADDR_WIDTH-1:0]            s_araddr,
   output logic [S_ID_WIDTH-1:0]            s_arid,
   output logic                             s_arvalid,
   input  logic                             s_arready,
   output logic [ADDR_WIDTH-1:0]            s_awaddr,
   output logic                             s_awvalid,
   input  logic                             s_awready,
   output logic [DATA_WIDTH-1:0]            s_wdata,
   output logic                             s_wvalid,
   input  logic                             s_wready,
   input  logic [DATA_WIDTH-1:0]            s_rdata,
   input  logic [S_ID_WIDTH-1:0]            s_rid,
   input  logic                             s_rvalid,
   output logic                             s_rready,
   input  logic                             s_bvalid,
   output logic                             s_bready,
   output logic                             dbg_rd_busy,
   output logic                             dbg_wr_busy,
   output logic [$clog2(B_DEPTH+1)-1:0]     dbg_b_count
);

   localparam int PTR_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
   localparam int CNT_W = $clog2(B_DEPTH + 1);

   // Handshake rule on every channel: a beat transfers on the rising edge where valid and ready are
   // both high. Valid never depends on ready. The ready driven to a master mirrors the slave's ready
   // only while that master holds the grant.

   typedef enum logic {RD_IDLE, RD_GRANT} rd_state_t;
   typedef enum logic {WR_IDLE, WR_XFER}  wr_state_t;

   rd_state_t              rd_state;
   wr_state_t              wr_state;
   logic [IDX_W-1:0]       rd_grant, rd_last, wr_grant, wr_last;
   logic                   aw_done, w_done, aw_now, w_now, b_push, b_pop, b_full, b_empty;
   logic [IDX_W-1:0]       r_idx, b_head;
   logic [IDX_W-1:0]       b_mem [B_DEPTH];
   logic [PTR_W-1:0]       b_wr_ptr, b_rd_ptr;
   logic [CNT_W-1:0]       b_count;

   // The first requester strictly after 'last', with wrap, so the previous winner goes to the back.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         idx = (int'(last) + k) % N_MASTERS;
         if (!found && req[idx]) begin
            pick  = idx[IDX_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(B_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= RD_IDLE;
         rd_grant <= '0;
         rd_last  <= IDX_W'(N_MASTERS - 1);
      end else begin
         case (rd_state)
            RD_IDLE: if (|m_arvalid) begin
               rd_grant <= rr_pick(m_arvalid, rd_last);
               rd_state <= RD_GRANT;
            end
            RD_GRANT: if (s_arvalid && s_arready) begin
               rd_last  <= rd_grant;
               rd_state <= RD_IDLE;
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   always_comb begin
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arid    = '0;
      m_arready = '0;
      if (rd_state == RD_GRANT) begin
         s_arvalid           = m_arvalid[rd_grant];
         s_araddr            = m_araddr[rd_grant*ADDR_WIDTH +: ADDR_WIDTH];
         s_arid              = {rd_grant, m_arid[rd_grant*M_ID_WIDTH +: M_ID_WIDTH]};
         m_arready[rd_grant] = s_arready;
      end
   end

   // A tag that names no master, possible only when N_MASTERS is not a power of two, is drained and dropped.
   assign r_idx   = s_rid[S_ID_WIDTH-1 -: IDX_W];
   assign m_rdata = {N_MASTERS{s_rdata}};
   assign m_rid   = {N_MASTERS{s_rid[M_ID_WIDTH-1:0]}};

   always_comb begin
      m_rvalid = '0;
      s_rready = 1'b1;
      if (int'(r_idx) < N_MASTERS) begin
         m_rvalid[r_idx] = s_rvalid;
         s_rready        = m_rready[r_idx];
      end
   end

   always_comb begin
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      m_awready = '0;
      m_wready  = '0;
      if (wr_state == WR_XFER) begin
         s_awvalid           = m_awvalid[wr_grant] & ~aw_done;
         s_awaddr            = m_awaddr[wr_grant*ADDR_WIDTH +: ADDR_WIDTH];
         m_awready[wr_grant] = s_awready & ~aw_done;
         s_wvalid            = m_wvalid[wr_grant] & ~w_done;
         s_wdata             = m_wdata[wr_grant*DATA_WIDTH +: DATA_WIDTH];
         m_wready[wr_grant]  = s_wready & ~w_done;
      end
   end

   assign aw_now = aw_done | (s_awvalid & s_awready);
   assign w_now  = w_done | (s_wvalid & s_wready);
   assign b_push = (wr_state == WR_XFER) & aw_now & w_now;

   // FIFO space is reserved at grant time, so a write already in progress can always complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         wr_grant <= '0;
         wr_last  <= IDX_W'(N_MASTERS - 1);
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (wr_state)
            WR_IDLE: if (!b_full && |(m_awvalid | m_wvalid)) begin
               wr_grant <= rr_pick(m_awvalid | m_wvalid, wr_last);
               aw_done  <= 1'b0;
               w_done   <= 1'b0;
               wr_state <= WR_XFER;
            end
            WR_XFER: if (b_push) begin
               wr_last  <= wr_grant;
               wr_state <= WR_IDLE;
            end else begin
               aw_done <= aw_now;
               w_done  <= w_now;
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   assign b_full  = (b_count == CNT_W'(B_DEPTH));
   assign b_empty = (b_count == '0);
   assign b_head  = b_mem[b_rd_ptr];
   assign b_pop   = s_bvalid & s_bready;

   always_comb begin
      m_bvalid = '0;
      s_bready = 1'b0;
      if (!b_empty) begin
         m_bvalid[b_head] = s_bvalid;
         s_bready         = m_bready[b_head];
      end
   end

   always_ff @(posedge clk) begin
      if (b_push) b_mem[b_wr_ptr] <= wr_grant;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b_wr_ptr <= '0;
         b_rd_ptr <= '0;
         b_count  <= '0;
      end else begin
         if (b_push) b_wr_ptr <= ptr_next(b_wr_ptr);
         if (b_pop)  b_rd_ptr <= ptr_next(b_rd_ptr);
         case ({b_push, b_pop})
            2'b10:   b_count <= b_count + 1'b1;
            2'b01:   b_count <= b_count - 1'b1;
            default: b_count <= b_count;
         endcase
      end
   end

   assign dbg_rd_busy = (rd_state == RD_GRANT);
   assign dbg_wr_busy = (wr_state == WR_XFER);
   assign dbg_b_count = b_count;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter: two masters, a behavioural in-order slave, response
// logs, and one task per scenario with inline checks.
module tb_axi_lite_master_arbiter;

   localparam int N = 2, AW = 32, DW = 32, MIDW = 2, IDXW = 1, SIDW = 3, BD = 4, CW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N*AW-1:0]   m_araddr, m_awaddr;
   logic [N*MIDW-1:0] m_arid, m_rid;
   logic [N*DW-1:0]   m_wdata, m_rdata;
   logic [N-1:0]      m_arvalid, m_arready, m_awvalid, m_awready, m_wvalid, m_wready;
   logic [N-1:0]      m_rvalid, m_rready, m_bvalid, m_bready;
   logic [AW-1:0]     s_araddr, s_awaddr;
   logic [SIDW-1:0]   s_arid, s_rid;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic              s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
   logic              s_rvalid, s_rready, s_bvalid, s_bready;
   logic              dbg_rd_busy, dbg_wr_busy;
   logic [CW-1:0]     dbg_b_count;
   logic              ar_en, aw_en, w_en;

   int n_checks = 0;
   int n_pass   = 0;

   axi_lite_master_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M_ID_WIDTH(MIDW),
                             .B_DEPTH(BD)) dut (
      .clk(clk), .rst(rst),
      .m_araddr(m_araddr), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_rdata(m_rdata), .m_rid(m_rid), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_rdata(s_rdata), .s_rid(s_rid), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .dbg_rd_busy(dbg_rd_busy), .dbg_wr_busy(dbg_wr_busy), .dbg_b_count(dbg_b_count)
   );

   // Behavioural slave: in-order responses. Unwritten addresses read back as ~addr.
   logic [31:0]        mem [logic [31:0]];
   logic [SIDW+DW-1:0] r_q[$];
   logic [AW-1:0]      aw_q[$];
   logic [DW-1:0]      w_q[$];
   int                 b_pend;
   logic [AW-1:0]      wa;
   logic [DW-1:0]      wd;

   assign s_arready = ar_en;
   assign s_awready = aw_en;
   assign s_wready  = w_en;

   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : ~a;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         r_q.delete(); aw_q.delete(); w_q.delete();
         b_pend = 0;
         s_rvalid <= 1'b0; s_bvalid <= 1'b0; s_rdata <= '0; s_rid <= '0;
      end else begin
         if (s_rvalid && s_rready) void'(r_q.pop_front());
         if (s_arvalid && s_arready) r_q.push_back({s_arid, slave_rd(s_araddr)});
         if (s_awvalid && s_awready) aw_q.push_back(s_awaddr);
         if (s_wvalid && s_wready) w_q.push_back(s_wdata);
         if (aw_q.size() > 0 && w_q.size() > 0) begin
            wa = aw_q.pop_front();
            wd = w_q.pop_front();
            mem[wa] = wd;
            b_pend++;
         end
         if (s_bvalid && s_bready) b_pend--;
         s_rvalid <= (r_q.size() > 0);
         if (r_q.size() > 0) {s_rid, s_rdata} <= r_q[0];
         s_bvalid <= (b_pend > 0);
      end
   end

   // Logs of completed master-side and slave-side handshakes.
   logic [IDXW+MIDW+DW-1:0] r_log[$];
   logic [SIDW-1:0]         ar_log[$];
   int                      aw_log[$];
   int                      b_log[$];

   always @(posedge clk) begin
      if (rst) begin
         r_log.delete(); ar_log.delete(); aw_log.delete(); b_log.delete();
      end else begin
         if (s_arvalid && s_arready) ar_log.push_back(s_arid);
         for (int i = 0; i < N; i++) begin
            if (m_rvalid[i] && m_rready[i])
               r_log.push_back({IDXW'(i), m_rid[i*MIDW +: MIDW], m_rdata[i*DW +: DW]});
            if (m_awvalid[i] && m_awready[i]) aw_log.push_back(i);
            if (m_bvalid[i] && m_bready[i]) b_log.push_back(i);
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
      m_rready = '1; m_bready = '1;
      ar_en = 1'b1; aw_en = 1'b1; w_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_read(input int m, input logic [31:0] addr, input logic [1:0] id);
      logic ok;
      ok = 1'b0;
      m_araddr[m*AW +: AW] = addr;
      m_arid[m*MIDW +: MIDW] = id;
      m_arvalid[m] = 1'b1;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (m_arready[m]) begin ok = 1'b1; @(negedge clk); break; end
         @(negedge clk);
      end
      m_arvalid[m] = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL read_handshake m%0d addr %0h got no arready exp arready", m, addr);
      else n_pass++;
   endtask

   task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data, input int wdly);
      logic ok_aw, ok_w;
      ok_aw = 1'b0;
      ok_w  = 1'b0;
      fork
         begin
            m_awaddr[m*AW +: AW] = addr;
            m_awvalid[m] = 1'b1;
            for (int c = 0; c < 300; c++) begin
               #1;
               if (m_awready[m]) begin ok_aw = 1'b1; @(negedge clk); break; end
               @(negedge clk);
            end
            m_awvalid[m] = 1'b0;
         end
         begin
            repeat (wdly) @(negedge clk);
            m_wdata[m*DW +: DW] = data;
            m_wvalid[m] = 1'b1;
            for (int c = 0; c < 300; c++) begin
               #1;
               if (m_wready[m]) begin ok_w = 1'b1; @(negedge clk); break; end
               @(negedge clk);
            end
            m_wvalid[m] = 1'b0;
         end
      join
      n_checks++;
      if (!(ok_aw && ok_w)) $display("FAIL write_handshake m%0d addr %0h got aw=%0b w=%0b exp 1 1", m, addr, ok_aw, ok_w);
      else n_pass++;
   endtask

   task automatic wait_r(input int n);
      for (int c = 0; c < 200 && r_log.size() < n; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_checks++;
      if (r_log.size() != n) $display("FAIL r_count got %0d exp %0d", r_log.size(), n);
      else n_pass++;
   endtask

   task automatic wait_b(input int n);
      for (int c = 0; c < 300 && b_log.size() < n; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_checks++;
      if (b_log.size() != n) $display("FAIL b_count got %0d exp %0d", b_log.size(), n);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_arvalid = '1; m_awvalid = '1; m_wvalid = '1;
      m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_arid = '0;
      m_rready = '1; m_bready = '1; ar_en = 1'b1; aw_en = 1'b1; w_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (m_arready !== 2'b00) $display("FAIL reset_m_arready got %b exp 00", m_arready); else n_pass++;
      n_checks++; if (m_awready !== 2'b00) $display("FAIL reset_m_awready got %b exp 00", m_awready); else n_pass++;
      n_checks++; if (m_wready !== 2'b00) $display("FAIL reset_m_wready got %b exp 00", m_wready); else n_pass++;
      n_checks++; if (s_arvalid !== 1'b0) $display("FAIL reset_s_arvalid got %b exp 0", s_arvalid); else n_pass++;
      n_checks++; if (s_awvalid !== 1'b0) $display("FAIL reset_s_awvalid got %b exp 0", s_awvalid); else n_pass++;
      n_checks++; if (s_wvalid !== 1'b0) $display("FAIL reset_s_wvalid got %b exp 0", s_wvalid); else n_pass++;
      n_checks++; if (m_bvalid !== 2'b00) $display("FAIL reset_m_bvalid got %b exp 00", m_bvalid); else n_pass++;
      n_checks++; if (s_bready !== 1'b0) $display("FAIL reset_s_bready got %b exp 0", s_bready); else n_pass++;
      n_checks++; if (dbg_b_count !== 3'd0) $display("FAIL reset_b_count got %0d exp 0", dbg_b_count); else n_pass++;
      n_checks++; if ({dbg_rd_busy, dbg_wr_busy} !== 2'b00) $display("FAIL reset_fsm_busy got %b exp 00", {dbg_rd_busy, dbg_wr_busy}); else n_pass++;
      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      apply_reset();
      do_write(0, 32'h10, 32'hA5A5, 0);
      wait_b(1);
      n_checks++; if (b_log[0] != 0) $display("FAIL single_b_master got %0d exp 0", b_log[0]); else n_pass++;
      do_read(0, 32'h10, 2'd1);
      wait_r(1);
      n_checks++; if (ar_log[0] !== 3'b001) $display("FAIL single_s_arid got %b exp 001", ar_log[0]); else n_pass++;
      n_checks++; if (r_log[0] !== {1'b0, 2'd1, 32'hA5A5})
         $display("FAIL single_r got m%0d id %0d data %0h exp m0 id 1 data a5a5", r_log[0][34], r_log[0][33:32], r_log[0][31:0]);
      else n_pass++;
   endtask

   task automatic test_read_contention();
      logic [IDXW+MIDW+DW-1:0] exp_q[$];
      logic [IDXW+MIDW+DW-1:0] exp_r;
      logic [31:0]             a;
      apply_reset();
      fork
         begin for (int k = 0; k < 4; k++) do_read(0, 32'h100 + 32'(4*k), 2'(k)); end
         begin for (int k = 0; k < 4; k++) do_read(1, 32'h200 + 32'(4*k), 2'(k)); end
      join
      wait_r(8);
      for (int k = 0; k < 8; k++) begin
         a = 32'h100 * 32'((k % 2) + 1) + 32'(4 * (k / 2));
         exp_q.push_back({IDXW'(k % 2), MIDW'(k / 2), ~a});
      end
      for (int k = 0; k < 8; k++) begin
         exp_r = exp_q.pop_front();
         n_checks++; if (ar_log[k] !== {IDXW'(k % 2), MIDW'(k / 2)})
            $display("FAIL contention_grant%0d got arid %b exp %b", k, ar_log[k], {IDXW'(k % 2), MIDW'(k / 2)});
         else n_pass++;
         n_checks++; if (r_log[k] !== exp_r)
            $display("FAIL contention_r%0d got %h exp %h", k, r_log[k], exp_r);
         else n_pass++;
      end
   endtask

   task automatic test_write_late_w();
      apply_reset();
      m_awaddr[AW +: AW] = 32'h20;
      m_awvalid[1] = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h20) $display("FAIL latew_aw_fwd got v=%b a=%h exp v=1 a=20", s_awvalid, s_awaddr); else n_pass++;
      n_checks++; if (m_awready !== 2'b10) $display("FAIL latew_awready got %b exp 10", m_awready); else n_pass++;
      n_checks++; if (s_wvalid !== 1'b0) $display("FAIL latew_early_wvalid got %b exp 0", s_wvalid); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (s_awvalid !== 1'b0) $display("FAIL latew_aw_done_valid got %b exp 0", s_awvalid); else n_pass++;
      n_checks++; if (m_awready !== 2'b00) $display("FAIL latew_aw_done_ready got %b exp 00", m_awready); else n_pass++;
      n_checks++; if (dbg_wr_busy !== 1'b1) $display("FAIL latew_wr_busy got %b exp 1", dbg_wr_busy); else n_pass++;
      @(negedge clk);
      m_awvalid[1] = 1'b0;
      m_wdata[DW +: DW] = 32'h1234;
      m_wvalid[1] = 1'b1;
      #1;
      n_checks++; if (s_wvalid !== 1'b1 || s_wdata !== 32'h1234) $display("FAIL latew_w_fwd got v=%b d=%h exp v=1 d=1234", s_wvalid, s_wdata); else n_pass++;
      n_checks++; if (m_wready !== 2'b10) $display("FAIL latew_wready got %b exp 10", m_wready); else n_pass++;
      @(negedge clk);
      m_wvalid[1] = 1'b0;
      #1;
      n_checks++; if (dbg_b_count !== 3'd1) $display("FAIL latew_b_count got %0d exp 1", dbg_b_count); else n_pass++;
      n_checks++; if (m_bvalid !== 2'b10) $display("FAIL latew_bvalid got %b exp 10", m_bvalid); else n_pass++;
      wait_b(1);
      n_checks++; if (b_log[0] != 1) $display("FAIL latew_b_master got %0d exp 1", b_log[0]); else n_pass++;
      n_checks++; if (aw_log.size() != 1) $display("FAIL latew_aw_count got %0d exp 1", aw_log.size()); else n_pass++;
      do_read(0, 32'h20, 2'd0);
      wait_r(1);
      n_checks++; if (r_log[0] !== {1'b0, 2'd0, 32'h1234}) $display("FAIL latew_readback got %h exp 000001234", r_log[0]); else n_pass++;
   endtask

   task automatic test_b_fifo_full();
      logic seen;
      apply_reset();
      m_bready = 2'b00;
      seen = 1'b0;
      fork
         begin for (int k = 0; k < 6; k++) do_write(0, 32'h300 + 32'(4*k), 32'hB000 + 32'(k), 0); end
         begin
            for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); seen = (dbg_b_count == 3'd4); end
            repeat (6) @(negedge clk);
            #1;
            n_checks++; if (dbg_b_count !== 3'd4) $display("FAIL full_b_count got %0d exp 4", dbg_b_count); else n_pass++;
            n_checks++; if (aw_log.size() != 4) $display("FAIL full_granted got %0d exp 4", aw_log.size()); else n_pass++;
            n_checks++; if (dbg_wr_busy !== 1'b0 || s_awvalid !== 1'b0) $display("FAIL full_blocked got busy=%b awv=%b exp 0 0", dbg_wr_busy, s_awvalid); else n_pass++;
            n_checks++; if (m_bvalid !== 2'b01) $display("FAIL full_bvalid got %b exp 01", m_bvalid); else n_pass++;
            m_bready = 2'b01;
         end
      join
      wait_b(6);
      for (int k = 0; k < 6; k++) begin
         n_checks++; if (b_log[k] != 0) $display("FAIL full_b%0d got m%0d exp m0", k, b_log[k]); else n_pass++;
      end
      n_checks++; if (aw_log.size() != 6) $display("FAIL full_total_aw got %0d exp 6", aw_log.size()); else n_pass++;
   endtask

   task automatic test_interleaved_writes();
      apply_reset();
      m_bready = 2'b01;
      fork
         begin for (int k = 0; k < 3; k++) do_write(0, 32'h400 + 32'(4*k), 32'hD000 + 32'(k), k); end
         begin for (int k = 0; k < 3; k++) do_write(1, 32'h500 + 32'(4*k), 32'hE000 + 32'(k), 0); end
         begin repeat (25) @(negedge clk); m_bready[1] = 1'b1; end
      join
      wait_b(6);
      for (int k = 0; k < 6; k++) begin
         n_checks++; if (aw_log[k] != k % 2) $display("FAIL inter_grant%0d got m%0d exp m%0d", k, aw_log[k], k % 2); else n_pass++;
         n_checks++; if (b_log[k] != k % 2) $display("FAIL inter_b%0d got m%0d exp m%0d", k, b_log[k], k % 2); else n_pass++;
      end
      do_read(1, 32'h504, 2'd3);
      wait_r(1);
      n_checks++; if (r_log[0] !== {1'b1, 2'd3, 32'hE001}) $display("FAIL inter_readback got %h exp 70000e001", r_log[0]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      m_bready = 2'b00;
      do_write(0, 32'h600, 32'h77, 0);
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (dbg_b_count !== 3'd1) $display("FAIL mid_pre_b_count got %0d exp 1", dbg_b_count); else n_pass++;
      do_read(0, 32'h600, 2'd2);
      ar_en = 1'b0;
      m_arid = {2'd3, 2'd0};
      m_arvalid = 2'b11;
      @(negedge clk); #1;
      n_checks++; if (s_arvalid !== 1'b1 || s_arid !== 3'b111) $display("FAIL mid_pre_grant got v=%b id=%b exp v=1 id=111", s_arvalid, s_arid); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (s_arvalid !== 1'b0 || dbg_rd_busy !== 1'b0) $display("FAIL mid_post_ar got v=%b busy=%b exp 0 0", s_arvalid, dbg_rd_busy); else n_pass++;
      n_checks++; if ({m_arready, m_awready, m_wready} !== 6'b0) $display("FAIL mid_post_ready got %b exp 000000", {m_arready, m_awready, m_wready}); else n_pass++;
      n_checks++; if (dbg_b_count !== 3'd0) $display("FAIL mid_post_b_count got %0d exp 0", dbg_b_count); else n_pass++;
      n_checks++; if (m_bvalid !== 2'b00 || s_bready !== 1'b0) $display("FAIL mid_post_b got bv=%b br=%b exp 00 0", m_bvalid, s_bready); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (s_arvalid !== 1'b1 || s_arid !== 3'b000) $display("FAIL mid_first_grant got v=%b id=%b exp v=1 id=000", s_arvalid, s_arid); else n_pass++;
      ar_en = 1'b1;
      @(negedge clk);
      m_arvalid = 2'b00;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_read_contention();
      test_write_late_w();
      test_b_fifo_full();
      test_interleaved_writes();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
- Shares one AXI-lite slave port (e.g. `axi_slave`) between N_MASTERS requesters.
- Uses independent round-robin arbitration for the read-address and write-address/data channels.
- Routes R responses back to the requester by the master index carried in the upper bits of the slave-side ID.
- Routes B responses in order through an internal FIFO of granted write masters.
- Sits between the master-side agents and the shared slave in the AXI testbench/SoC.

Parameters:
- N_MASTERS, 2: number of requesting masters (2..8).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- M_ID_WIDTH, 2: master-side ID width.
- IDX_W, $clog2(N_MASTERS): master index width (derived).
- S_ID_WIDTH, M_ID_WIDTH+IDX_W: slave-side ID width (derived).
- B_DEPTH, 4: depth of the outstanding-write routing FIFO.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m_araddr  in  N_MASTERS*ADDR_WIDTH  per-master read address, slice i = master i
- m_arid  in  N_MASTERS*M_ID_WIDTH  per-master read ID
- m_arvalid  in  N_MASTERS  read-address valid
- m_arready  out  N_MASTERS  read-address ready
- m_awaddr  in  N_MASTERS*ADDR_WIDTH  write address
- m_awvalid  in  N_MASTERS  write-address valid
- m_awready  out  N_MASTERS  write-address ready
- m_wdata  in  N_MASTERS*DATA_WIDTH  write data
- m_wvalid  in  N_MASTERS  write-data valid
- m_wready  out  N_MASTERS  write-data ready
- m_rdata  out  N_MASTERS*DATA_WIDTH  read data, s_rdata broadcast to every slice
- m_rid  out  N_MASTERS*M_ID_WIDTH  read ID, low M_ID_WIDTH bits of s_rid broadcast
- m_rvalid  out  N_MASTERS  read valid, only the addressed master
- m_rready  in  N_MASTERS  read ready
- m_bvalid  out  N_MASTERS  write response valid
- m_bready  in  N_MASTERS  write response ready
- s_araddr/s_arid/s_arvalid  out  ADDR_WIDTH/S_ID_WIDTH/1  to slave
- s_arready  in  1
- s_awaddr/s_awvalid  out  ADDR_WIDTH/1
- s_awready  in  1
- s_wdata/s_wvalid  out  DATA_WIDTH/1
- s_wready  in  1
- s_rdata/s_rid/s_rvalid  in  DATA_WIDTH/S_ID_WIDTH/1
- s_rready  out  1
- s_bvalid  in  1
- s_bready  out  1

Behaviour:
- **Reset**
  - Read FSM and write FSM go to IDLE.
  - rd_last = wr_last = N_MASTERS-1, so master 0 wins first.
  - B FIFO is emptied (count=0).
  - All m_arready/m_awready/m_wready = 0; s_arvalid/s_awvalid/s_wvalid = 0.
  - aw_done = w_done = 0.
  - Reset mid-transaction discards all grants and outstanding B entries with no completion. The slave is reset in the same cycle.
- **Read FSM: RD_IDLE -> RD_GRANT**
  - RD_IDLE: if any m_arvalid, the grant g is registered as the first requester searching from (rd_last+1) mod N_MASTERS upward with wrap. This gives 1 cycle of arbitration latency.
  - RD_GRANT, combinational:
    - s_arvalid = m_arvalid[g]
    - s_araddr = m_araddr[g]
    - s_arid = {g, m_arid[g]}
    - m_arready[g] = s_arready; other m_arready = 0
  - On s_arvalid & s_arready: rd_last <= g, go to RD_IDLE.
  - The grant is held while the granted master keeps arvalid; it is never preempted.
- **R routing (combinational, no storage)**
  - idx = s_rid[S_ID_WIDTH-1 -: IDX_W].
  - m_rvalid[idx] = s_rvalid; s_rready = m_rready[idx].
  - If idx >= N_MASTERS: s_rready = 1 and the beat is dropped.
  - R and AR are fully independent; out-of-order rids interleaved across masters are legal.
- **Write FSM: WR_IDLE -> WR_XFER**
  - WR_IDLE: if B FIFO not full and any master has (m_awvalid|m_wvalid), register round-robin grant g from wr_last; aw_done = w_done = 0.
  - WR_XFER:
    - s_awvalid = m_awvalid[g] & ~aw_done; m_awready[g] = s_awready & ~aw_done.
    - s_wvalid = m_wvalid[g] & ~w_done; m_wready[g] = s_wready & ~w_done.
    - Handshakes set aw_done / w_done.
  - When both are complete (same cycle allowed): push g into B FIFO, wr_last <= g, go to WR_IDLE.
  - A full FIFO blocks new write grants only. It never stalls a write already in WR_XFER, because fullness is checked at grant time.
- **B routing**
  - head = FIFO front.
  - When count > 0: m_bvalid[head] = s_bvalid; s_bready = m_bready[head].
  - When count = 0: all m_bvalid = 0, s_bready = 0.
  - Pop on s_bvalid & s_bready. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo B_DEPTH.

Test Plan:
- **Single read.** M0 AR addr 0x10 id 1 after a prior write of 0xA5A5 -> slave sees s_arid=0b001; M0 gets rvalid with rdata 0xA5A5, rid 1; M1 rvalid stays 0.
- **Read contention.** M0 and M1 both assert arvalid continuously for 4 reads each -> grants alternate 0,1,0,1,...; each master receives exactly its 4 responses with correct rids.
- **Write with late W.** M1 AW 0x20 at cycle 0, W 0x1234 at cycle 3 -> s_awvalid deasserts after AW accepted; s_wvalid asserts at cycle 3; M1 gets exactly one bvalid; M0 gets none.
- **B FIFO full.** B_DEPTH=4, m_bready held 0, M0 issues 6 writes -> 4 writes are granted, the 5th is not granted until one B pops; all 6 B responses eventually go to M0 in order.
- **Interleaved writes.** M0/M1 writes interleaved with mixed bready stall -> B delivered to masters in grant order.
- **Reset mid-operation.** rst during RD_GRANT with s_arready=0 -> next cycle all readys/valids are 0, FIFO count is 0, and the next arbitration grants M0 first.
